scroll_controller: RTL and testbench
====================================

// Module: scroll_controller
// PURPOSE
//  Sequences the digit scroller. Conditions the raw left/right push-buttons through
//  synchronizer, debounce and edge-detect stages, and owns the window position
//  register. It can also step the window automatically on a timer.
//  pos drives the select lines of the window muxes; 0 = leftmost window.
//  It replaces the button-OR-as-clock counter with a single-clock design.
// PARAMETERS
//  NUM_DIGITS      5  digits in the source row (>= WINDOW+1)
//  WINDOW          3  digits visible at once; MAX_POS = NUM_DIGITS-WINDOW (2)
//  DEBOUNCE_CYCLES 4  consecutive stable synced samples needed to accept a level
//  AUTO_PERIOD     8  clk cycles between automatic steps (>= 2)
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  btn_left    in   1  raw push-button, asynchronous, high = pressed
//  btn_right   in   1  raw push-button, asynchronous, high = pressed
//  auto_en     in   1  synchronous level; 1 = automatic scrolling enabled
//  wrap_en     in   1  synchronous level; 1 = wrap at ends, 0 = clamp/ping-pong
//  pos         out  3  leftmost visible digit index, 0..MAX_POS
//  step_pulse  out  1  one-cycle strobe, high in the cycle after pos changes
//  at_left     out  1  pos == 0 (combinational from the pos register)
//  at_right    out  1  pos == MAX_POS (combinational from the pos register)
// BEHAVIOUR
//  Reset (reset=0): pos=0, step_pulse=0, debouncers IDLE, auto timer=0, auto_dir=right.
//   at_left=1 and at_right=0 during reset.
//  Sync: each button passes through a 2-FF synchronizer before any logic.
//  Debounce FSM per button: IDLE -> PRESS_WAIT -> HELD -> RELEASE_WAIT -> IDLE.
//   - IDLE->PRESS_WAIT on synced=1. The counter loads 1.
//   - PRESS_WAIT: synced=1 increments the counter. Reaching DEBOUNCE_CYCLES -> HELD
//     and raises a one-cycle press event. synced=0 -> IDLE.
//   - HELD->RELEASE_WAIT on synced=0.
//   - RELEASE_WAIT: DEBOUNCE_CYCLES consecutive 0s -> IDLE. Any 1 -> HELD with no event.
//   - One press event per press, however long the button is held. There is no auto-repeat.
//  Latency: pos updates DEBOUNCE_CYCLES+3 rising edges after the first edge that samples
//   the raw button high. The button must stay high throughout. step_pulse follows 1 cycle later.
//  Step arbitration, evaluated each cycle in priority order:
//   1. Left and right press events in the same cycle: both are discarded. No step, no pulse.
//   2. Single manual event: left = pos-1, right = pos+1. The auto timer clears to 0.
//   3. auto_en=1 and the timer reaches AUTO_PERIOD-1: step in auto_dir. The timer clears to 0.
//   The timer only counts while auto_en=1. It holds at 0 while auto_en=0.
//  Boundaries:
//   - Manual or auto step beyond an end with wrap_en=1: wrap (MAX_POS+1 -> 0, -1 -> MAX_POS).
//   - Manual step beyond an end with wrap_en=0: pos is unchanged. No step_pulse is raised.
//   - Auto step with wrap_en=0: ping-pong. auto_dir flips on reaching 0 or MAX_POS,
//     so the next auto step moves away from that end.
//   - A manual step never changes auto_dir.
//  pos never leaves 0..MAX_POS. All arithmetic is done in 3 bits and compared against MAX_POS.
//  Reset mid-operation forces all state to its reset values immediately.
//   A button still held when reset deasserts is treated as a new press and debounced normally.
// TESTING (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, NUM_DIGITS=5, WINDOW=3)
//  1. btn_right held 12 cycles from pos=0 -> pos=1 on edge 7, exactly one step_pulse.
//     Release, then press again -> pos=2.
//  2. btn_right bounce (1,1,0,1,0 then low) -> pos stays 0, no step_pulse.
//  3. pos=2, wrap_en=0, right press -> pos=2, no pulse, at_right=1.
//     Repeat with wrap_en=1 -> pos=0, at_left=1.
//  4. Both buttons pressed on the same cycle -> no step. pos and step_pulse are unchanged.
//  5. auto_en=1, wrap_en=0 from reset -> pos 1,2,1,0,1 at 8-cycle spacing.
//     A manual left press mid-period restarts the 8-cycle count.
//  6. Hold btn_left, assert reset during HELD -> pos=0 and FSMs IDLE.
//     Deassert with button still held -> one press, pos wraps to 2 if wrap_en=1, else stays 0.

Source files
------------

// File: rtl/scroll_controller.sv
// Digit-scroller sequencer: conditions the left/right buttons and steps the
// window position manually or on a timer, all in a single clock domain.
module scroll_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          sync1, synced, press_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1  <= raw;
      synced <= sync1;
      state  <= state_next;
      cnt    <= cnt_next;
      press  <= press_next;
    end
  end

  // cnt holds the number of consecutive matching samples already seen
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    unique case (state)
      IDLE: if (synced) begin
        state_next = PRESS_WAIT;
        cnt_next   = ONE;
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      HELD: if (!synced) begin
        state_next = RELEASE_WAIT;
        cnt_next   = ONE;
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt >= LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end
endmodule

module scroll_controller #(
  parameter int unsigned NUM_DIGITS      = 5,
  parameter int unsigned WINDOW          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       auto_en,
  input  logic       wrap_en,
  output logic [2:0] pos,
  output logic       step_pulse,
  output logic       at_left,
  output logic       at_right
);
  localparam logic [2:0] MAX_POS = 3'(NUM_DIGITS - WINDOW);
  localparam int unsigned TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_t;

  logic          press_left, press_right;
  logic [2:0]    pos_next;
  logic [TW-1:0] timer, timer_next;
  dir_t          dir, dir_next;
  logic          move_right, stepped;

  scroll_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .raw(btn_left), .press(press_left)
  );
  scroll_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .raw(btn_right), .press(press_right)
  );

  always_comb begin
    pos_next   = pos;
    dir_next   = dir;
    move_right = 1'b0;
    timer_next = (auto_en && timer != TIMER_LAST) ? timer + TIMER_ONE : '0;
    if (press_left && press_right) begin
      pos_next = pos;
    end else if (press_left || press_right) begin
      timer_next = '0;
      if (press_right) pos_next = (pos == MAX_POS) ? (wrap_en ? 3'd0 : pos) : pos + 3'd1;
      else             pos_next = (pos == 3'd0) ? (wrap_en ? MAX_POS : pos) : pos - 3'd1;
    end else if (auto_en && timer == TIMER_LAST) begin
      // without wrap, an outward-facing direction bounces off the end it is on
      if (wrap_en) move_right = (dir == DIR_RIGHT);
      else         move_right = (dir == DIR_RIGHT) ? (pos != MAX_POS) : (pos == 3'd0);
      if (move_right) pos_next = (pos == MAX_POS) ? 3'd0 : pos + 3'd1;
      else            pos_next = (pos == 3'd0) ? MAX_POS : pos - 3'd1;
      if (!wrap_en)
        dir_next = (pos_next == MAX_POS) ? DIR_LEFT :
                   (pos_next == 3'd0)    ? DIR_RIGHT :
                   (move_right ? DIR_RIGHT : DIR_LEFT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos        <= 3'd0;
      dir        <= DIR_RIGHT;
      timer      <= '0;
      stepped    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      pos        <= pos_next;
      dir        <= dir_next;
      timer      <= timer_next;
      stepped    <= (pos_next != pos);
      step_pulse <= stepped;
    end
  end

  assign at_left  = (pos == 3'd0);
  assign at_right = (pos == MAX_POS);
endmodule

// File: tb/tb_scroll_controller.sv
// Randomised and directed bench for scroll_controller with a scoreboard fed by
// an abstract position model and drained by a step_pulse monitor.
module tb_scroll_controller;
  localparam int D    = 4;
  localparam int P    = 8;
  localparam int MAXP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, auto_en = 1'b0, wrap_en = 1'b0;
  logic [2:0] pos;
  logic       step_pulse, at_left, at_right;

  int checks = 0, failures = 0;
  int cyc = 0;
  int m_pos = 0, m_timer = 0;
  bit m_right = 1'b1;
  int exp_q[$];
  bit left_at[int];
  bit right_at[int];
  int pulse_count = 0;
  logic [2:0] pos_prev = 3'd0;

  always #5 clk = ~clk;

  scroll_controller #(.NUM_DIGITS(5), .WINDOW(3), .DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .auto_en(auto_en), .wrap_en(wrap_en), .pos(pos), .step_pulse(step_pulse),
    .at_left(at_left), .at_right(at_right)
  );

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a press accepted at an edge is known from when the raw
  // button went high; steps follow the arbitration and boundary rules.
  always @(posedge clk) begin
    bit l, r;
    int old, n;
    cyc++;
    if (!reset) begin
      m_pos = 0; m_timer = 0; m_right = 1'b1;
      exp_q.delete(); left_at.delete(); right_at.delete();
    end else begin
      l = left_at.exists(cyc);
      r = right_at.exists(cyc);
      old = m_pos;
      if (l && r) begin
        m_timer = (auto_en && m_timer < P-1) ? m_timer + 1 : 0;
      end else if (l || r) begin
        m_timer = 0;
        n = m_pos + (r ? 1 : -1);
        if (n >= 0 && n <= MAXP) m_pos = n;
        else if (wrap_en) m_pos = (n + MAXP + 1) % (MAXP + 1);
      end else if (auto_en && m_timer == P-1) begin
        m_timer = 0;
        if (wrap_en) begin
          m_pos = (m_pos + (m_right ? 1 : -1) + MAXP + 1) % (MAXP + 1);
        end else begin
          if ((m_right && m_pos == MAXP) || (!m_right && m_pos == 0)) m_right = !m_right;
          m_pos = m_pos + (m_right ? 1 : -1);
          if (m_pos == MAXP) m_right = 1'b0;
          if (m_pos == 0)    m_right = 1'b1;
        end
      end else begin
        m_timer = auto_en ? m_timer + 1 : 0;
      end
      if (m_pos != old) exp_q.push_back(m_pos);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("pos_model", pos, m_pos);
      check("at_left", at_left, m_pos == 0);
      check("at_right", at_right, m_pos == MAXP);
      if (step_pulse) begin
        pulse_count++;
        check("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("step_pos", pos_prev, exp_q.pop_front());
      end
    end
    pos_prev = pos;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check("rst_pos", pos, 0);
    check("rst_pulse", step_pulse, 0);
    check("rst_at_left", at_left, 1);
    check("rst_at_right", at_right, 0);
    tick(2);
    reset = 1'b1;
  endtask

  task automatic press(bit l, bit r, int hold);
    int e;
    e = cyc;
    if (l) left_at[e + D + 3] = 1'b1;
    if (r) right_at[e + D + 3] = 1'b1;
    btn_left = l; btn_right = r;
    tick(hold);
    btn_left = 1'b0; btn_right = 1'b0;
    tick(D + 4);
  endtask

  initial begin
    int e, p0, pick, len;
    @(posedge clk);
    #2;
    do_reset();

    // 1: held right press, exact latency and single pulse
    e = cyc; p0 = pulse_count;
    right_at[e + D + 3] = 1'b1;
    btn_right = 1'b1;
    tick(6);  check("t1_pos_before", pos, 0);
    tick(1);  check("t1_pos_edge7", pos, 1); check("t1_pulse_edge7", step_pulse, 0);
    tick(1);  check("t1_pulse_edge8", step_pulse, 1);
    tick(1);  check("t1_pulse_edge9", step_pulse, 0);
    tick(3);
    btn_right = 1'b0;
    tick(D + 4);
    check("t1_one_pulse", pulse_count - p0, 1);
    press(1'b0, 1'b1, 6);
    check("t1_second_press", pos, 2);

    // 2: bounce too short to be accepted
    do_reset();
    p0 = pulse_count;
    btn_right = 1'b1; tick(2);
    btn_right = 1'b0; tick(1);
    btn_right = 1'b1; tick(1);
    btn_right = 1'b0; tick(D + 4);
    check("t2_pos", pos, 0);
    check("t2_pulses", pulse_count - p0, 0);

    // 3: right end, clamp then wrap
    press(1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 5);
    check("t3_at_max", pos, 2);
    wrap_en = 1'b0; p0 = pulse_count;
    press(1'b0, 1'b1, 5);
    check("t3_clamp_pos", pos, 2);
    check("t3_clamp_at_right", at_right, 1);
    check("t3_clamp_pulses", pulse_count - p0, 0);
    wrap_en = 1'b1;
    press(1'b0, 1'b1, 5);
    check("t3_wrap_pos", pos, 0);
    check("t3_wrap_at_left", at_left, 1);

    // 4: simultaneous presses cancel
    wrap_en = 1'b0;
    press(1'b0, 1'b1, 5);
    p0 = pulse_count;
    press(1'b1, 1'b1, 8);
    check("t4_pos", pos, 1);
    check("t4_pulses", pulse_count - p0, 0);

    // 5: auto ping-pong, then manual press restarts the period
    auto_en = 1'b1; wrap_en = 1'b0;
    do_reset();
    tick(8); check("t5_auto1", pos, 1);
    tick(8); check("t5_auto2", pos, 2);
    tick(8); check("t5_auto3", pos, 1);
    tick(8); check("t5_auto4", pos, 0);
    tick(8); check("t5_auto5", pos, 1);
    e = cyc;
    left_at[e + D + 3] = 1'b1;
    btn_left = 1'b1;
    tick(7); check("t5_manual_left", pos, 0);
    tick(1); check("t5_timer_restarted", pos, 0);
    btn_left = 1'b0;
    tick(7); check("t5_auto_after_manual", pos, 1);
    auto_en = 1'b0;
    tick(D + 4);

    // 6: reset while held, button still held at release of reset
    for (int w = 1; w >= 0; w--) begin
      wrap_en = 1'b0;
      do_reset();
      p0 = pulse_count;
      left_at[cyc + D + 3] = 1'b1;
      btn_left = 1'b1;
      tick(D + 6);
      reset = 1'b0;
      #1;
      check("t6_rst_pos", pos, 0);
      check("t6_rst_pulse", step_pulse, 0);
      tick(2);
      wrap_en = w[0];
      reset = 1'b1;
      left_at[cyc + D + 3] = 1'b1;
      tick(D + 5);
      check("t6_pos_after", pos, (w == 1) ? 2 : 0);
      btn_left = 1'b0;
      tick(D + 4);
      check("t6_pulses", pulse_count - p0, (w == 1) ? 1 : 0);
    end

    // random mix of presses, bounces, mode changes and idle time
    wrap_en = 1'b0; auto_en = 1'b0;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 2)      press(1'b1, 1'b0, $urandom_range(D, 14));
      else if (pick <= 5) press(1'b0, 1'b1, $urandom_range(D, 14));
      else if (pick == 6) begin
        len = $urandom_range(1, D - 1);
        if ($urandom_range(0, 1) == 1) btn_left = 1'b1; else btn_right = 1'b1;
        tick(len);
        btn_left = 1'b0; btn_right = 1'b0;
        tick(D + 4);
      end
      else if (pick == 7) begin wrap_en = ~wrap_en; tick(1); end
      else if (pick == 8) begin auto_en = ~auto_en; tick(1); end
      else tick($urandom_range(1, 20));
    end
    auto_en = 1'b0;
    tick(20);
    check("final_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
